// File: rtl/number_sampler.sv
// Numbers-overlay readout sampler: four producers write a shadow bank through a
// round-robin req/ack port; the displayed bank swaps in at throttled frame ticks.
module number_sampler_lane #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             gnt,
  input  logic             swap,
  input  logic [WIDTH-1:0] din,
  output logic             pending,
  output logic [WIDTH-1:0] disp
);
  logic [WIDTH-1:0] shadow;

  // A grant landing on the swap edge: display takes the old shadow, the new
  // write stays pending.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow  <= '0;
      disp    <= '0;
      pending <= 1'b0;
    end else begin
      if (gnt)             shadow <= din;
      if (swap && pending) disp   <= shadow;
      pending <= gnt | (pending & ~swap);
    end
  end
endmodule

module number_sampler #(
  parameter int WIDTH       = 16,
  parameter int HOLD_FRAMES = 15
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             frame_tick,
  input  logic             freeze,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  input  logic [WIDTH-1:0] data3,
  output logic [3:0]       ack,
  output logic [WIDTH-1:0] var1,
  output logic [WIDTH-1:0] var2,
  output logic [WIDTH-1:0] var3,
  output logic [WIDTH-1:0] var4,
  output logic             update,
  output logic [3:0]       pending
);
  localparam int NUM_LANES = 4;
  localparam logic [7:0] HOLD = 8'(HOLD_FRAMES);

  logic [NUM_LANES-1:0][WIDTH-1:0] din, disp;
  logic [NUM_LANES-1:0] elig, gnt;
  logic [1:0] ptr, gidx;
  logic [7:0] fcnt;
  logic       found, due, swap;

  assign din  = {data3, data2, data1, data0};
  assign elig = req & ~ack;   // blocks a second capture while ack is still high
  assign due  = frame_tick && (fcnt == HOLD);
  assign swap = due && !freeze;

  always_comb begin
    gnt   = '0;
    gidx  = ptr;
    found = 1'b0;
    for (int k = 0; k < NUM_LANES; k++) begin
      if (!found && elig[ptr + 2'(k)]) begin
        found = 1'b1;
        gidx  = ptr + 2'(k);
      end
    end
    if (found) gnt[gidx] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ack    <= '0;
      ptr    <= '0;
      fcnt   <= '0;
      update <= 1'b0;
    end else begin
      ack    <= gnt;
      update <= swap && (|pending);
      if (found)      ptr  <= gidx + 2'd1;
      if (frame_tick) fcnt <= due ? 8'd0 : fcnt + 8'd1;
    end
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    number_sampler_lane #(.WIDTH(WIDTH)) u_lane (
      .clk     (clk),
      .reset_n (reset_n),
      .gnt     (gnt[i]),
      .swap    (swap),
      .din     (din[i]),
      .pending (pending[i]),
      .disp    (disp[i])
    );
  end

  assign var1 = disp[0];
  assign var2 = disp[1];
  assign var3 = disp[2];
  assign var4 = disp[3];
endmodule
